fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the code-memory address from PC, registers the returned
// word into ir, and stops on the halt word until reset.
module fetch_unit #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [15:0] HALT_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  mem_addr,
  input  logic [15:0] mem_data,
  input  logic        stall,
  input  logic        jump,
  input  logic [7:0]  jump_addr,
  output logic [15:0] ir,
  output logic [7:0]  ir_pc,
  output logic        ir_valid,
  output logic        halted,
  output logic [15:0] instr_count
);

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  ir_pc_q, ir_pc_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    count_d = count_q;
    if (state_q == StRun) begin
      // Jump outranks both stall and a halt word on the bus.
      if (jump) begin
        pc_d    = jump_addr;
        valid_d = 1'b0;
      end else if (!stall) begin
        if (mem_data == HALT_WORD) begin
          state_d = StHalt;
          valid_d = 1'b0;
        end else begin
          ir_d    = mem_data;
          ir_pc_d = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 8'd1;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      ir_pc_q <= 8'h00;
      valid_q <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign mem_addr    = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = valid_q;
  assign halted      = (state_q == StHalt);
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences, and
// randomized traffic against a behavioural model, then a counter saturation run.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic        stall;
  logic        jump;
  logic [7:0]  jump_addr;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        halted;
  logic [15:0] instr_count;

  logic [15:0] mem [256];
  assign mem_data = mem[mem_addr];

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .stall      (stall),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .halted     (halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        jump;
    logic [7:0]  jaddr;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        valid;
    logic        halted;
    logic [7:0]  addr;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[9];

  // Behavioural model state
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [7:0]  m_ir_pc;
  logic        m_valid;
  logic        m_halted;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    jump = 1'b0;
    jump_addr = 8'h00;
    step();
    reset = 1'b0;
    m_pc = 8'h00; m_ir = 16'h0000; m_ir_pc = 8'h00;
    m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  mem_addr, 8'h00);
    check({tag, "_ir"},    ir, 16'h0000);
    check({tag, "_irpc"},  ir_pc, 8'h00);
    check({tag, "_valid"}, ir_valid, 1'b0);
    check({tag, "_halt"},  halted, 1'b0);
    check({tag, "_cnt"},   instr_count, 16'h0000);
  endtask

  // Apply the architectural rules for one rising edge.
  task automatic model_edge();
    logic [15:0] word;
    word = mem[m_pc];
    if (m_halted) begin
    end else if (jump) begin
      m_pc = jump_addr;
      m_valid = 1'b0;
    end else if (stall) begin
    end else if (word == 16'h0000) begin
      m_halted = 1'b1;
      m_valid = 1'b0;
    end else begin
      m_ir = word;
      m_ir_pc = m_pc;
      m_valid = 1'b1;
      m_pc = m_pc + 8'd1;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1101; mem[8'h01] = 16'h1202; mem[8'h02] = 16'h1303; mem[8'h03] = 16'h0000;
    mem[8'h40] = 16'h4040; mem[8'h41] = 16'h0000;
    mem[8'h10] = 16'h1010; mem[8'hFF] = 16'hFFFE;

    //          stall jump jaddr  ir        irpc   v     h     addr   cnt
    tbl[0] = '{1'b0, 1'b0, 8'h00, 16'h1101, 8'h00, 1'b1, 1'b0, 8'h01, 16'd1};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 16'h1202, 8'h01, 1'b1, 1'b0, 8'h02, 16'd2};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 16'h1202, 8'h01, 1'b1, 1'b0, 8'h02, 16'd2};
    tbl[3] = '{1'b1, 1'b0, 8'h00, 16'h1202, 8'h01, 1'b1, 1'b0, 8'h02, 16'd2};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 16'h1202, 8'h01, 1'b1, 1'b0, 8'h02, 16'd2};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 16'h1303, 8'h02, 1'b1, 1'b0, 8'h03, 16'd3};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 16'h1303, 8'h02, 1'b0, 1'b1, 8'h03, 16'd3};
    tbl[7] = '{1'b0, 1'b1, 8'h40, 16'h1303, 8'h02, 1'b0, 1'b1, 8'h03, 16'd3};
    tbl[8] = '{1'b1, 1'b0, 8'h00, 16'h1303, 8'h02, 1'b0, 1'b1, 8'h03, 16'd3};

    // Reset held across edges
    reset = 1'b1; stall = 1'b0; jump = 1'b0; jump_addr = 8'h00;
    step(); step();
    check_reset_vals("rst_hold");
    reset = 1'b0;

    // Sequential fetch with stall, halt, and ignored inputs in HALT
    for (int i = 0; i < 9; i++) begin
      stall = tbl[i].stall; jump = tbl[i].jump; jump_addr = tbl[i].jaddr;
      step();
      check($sformatf("tbl%0d_ir", i),    ir, tbl[i].ir);
      check($sformatf("tbl%0d_irpc", i),  ir_pc, tbl[i].ir_pc);
      check($sformatf("tbl%0d_valid", i), ir_valid, tbl[i].valid);
      check($sformatf("tbl%0d_halt", i),  halted, tbl[i].halted);
      check($sformatf("tbl%0d_addr", i),  mem_addr, tbl[i].addr);
      check($sformatf("tbl%0d_cnt", i),   instr_count, tbl[i].cnt);
    end

    // Async reset while halted, between edges
    stall = 1'b0; jump = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    #1 reset = 1'b0;
    step();
    check("restart_ir", ir, 16'h1101);
    check("restart_irpc", ir_pc, 8'h00);
    check("restart_cnt", instr_count, 16'd1);

    // Jump with stall, jump over halt word, PC wrap
    step();
    jump = 1'b1; jump_addr = 8'h40; stall = 1'b1;
    step();
    check("jmpst_addr", mem_addr, 8'h40);
    check("jmpst_valid", ir_valid, 1'b0);
    check("jmpst_ir", ir, 16'h1202);
    check("jmpst_irpc", ir_pc, 8'h01);
    check("jmpst_cnt", instr_count, 16'd2);
    jump = 1'b0; stall = 1'b0;
    step();
    check("jmp_tgt_ir", ir, 16'h4040);
    check("jmp_tgt_irpc", ir_pc, 8'h40);
    check("jmp_tgt_valid", ir_valid, 1'b1);
    jump = 1'b1; jump_addr = 8'h10;
    step();
    check("jmphalt_halt", halted, 1'b0);
    check("jmphalt_addr", mem_addr, 8'h10);
    jump = 1'b0;
    step();
    check("jmphalt_ir", ir, 16'h1010);
    jump = 1'b1; jump_addr = 8'hFF;
    step();
    check("wrap_jaddr", mem_addr, 8'hFF);
    jump = 1'b0;
    step();
    check("wrap_irpc_ff", ir_pc, 8'hFF);
    check("wrap_ir_ff", ir, 16'hFFFE);
    check("wrap_addr0", mem_addr, 8'h00);
    step();
    check("wrap_irpc_00", ir_pc, 8'h00);
    check("wrap_ir_00", ir, 16'h1101);
    check("wrap_halt", halted, 1'b0);

    // Randomized episodes against the model
    for (int ep = 0; ep < 8; ep++) begin
      for (int i = 0; i < 256; i++)
        mem[i] = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
      do_reset();
      for (int c = 0; c < 60; c++) begin
        stall = ($urandom_range(0, 3) == 0);
        jump = ($urandom_range(0, 7) == 0);
        jump_addr = 8'($urandom);
        model_edge();
        step();
        check("rnd_ir", ir, m_ir);
        check("rnd_irpc", ir_pc, m_ir_pc);
        check("rnd_valid", ir_valid, m_valid);
        check("rnd_halt", halted, m_halted);
        check("rnd_addr", mem_addr, m_pc);
        check("rnd_cnt", instr_count, m_cnt[15:0]);
      end
    end

    // Count saturation: straight-line fetch through a memory with no halt words
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000 | 16'(i);
    do_reset();
    for (int c = 0; c < 65534; c++) step();
    check("sat_pre", instr_count, 16'hFFFE);
    step();
    check("sat_hit", instr_count, 16'hFFFF);
    step(); step(); step();
    check("sat_hold", instr_count, 16'hFFFF);
    check("sat_valid", ir_valid, 1'b1);
    check("sat_halt", halted, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
